// File: rtl/video_system_cpu_trace_packer.sv
// Packs narrow trace fragments into wide words and hands them to a consumer with
// a valid/ready handshake; a test_ending request flushes the partial word and ends the capture.
module video_system_cpu_trace_packer #(
  parameter int FRAG_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frag_valid,
  input  logic [FRAG_W-1:0]         frag_data,
  output logic                      frag_ready,
  input  logic                      test_ending,
  output logic [FRAG_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      test_has_ended
);

  typedef enum logic [1:0] {FILL, HOLD, ENDED} state_t;

  state_t                    state_reg;
  logic [FRAG_W*SLOTS-1:0]   buffer_reg;
  logic [FRAG_W*SLOTS-1:0]   buffer_next;
  logic [CNT_W-1:0]          count_reg;
  logic [CNT_W-1:0]          count_next;
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic                      ended_reg;
  logic                      end_pending_reg;
  logic                      accept;

  assign frag_ready = (state_reg == FILL) & ~reset;
  assign accept     = frag_valid & frag_ready;
  assign count_next = count_reg + {{(CNT_W-1){1'b0}}, accept};

  // Each slot captures the incoming fragment only when the write pointer addresses it.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign buffer_next[gi*FRAG_W +: FRAG_W] =
        (accept && (count_reg == CNT_W'(gi))) ? frag_data : buffer_reg[gi*FRAG_W +: FRAG_W];
  end

  assign dct_buffer     = buffer_reg;
  assign dct_count      = count_reg;
  assign out_valid      = out_valid_reg;
  assign test_has_ended = ended_reg;
  // An end request arriving during HOLD marks the held word as last, even on the handshake cycle.
  assign out_last       = out_last_reg | end_pending_reg |
                          ((state_reg == HOLD) & test_ending & ~reset);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FILL;
      buffer_reg      <= '0;
      count_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      ended_reg       <= 1'b0;
      end_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          buffer_reg <= buffer_next;
          count_reg  <= count_next;
          if (test_ending) begin
            if (count_next != '0) begin
              state_reg     <= HOLD;
              out_valid_reg <= 1'b1;
              out_last_reg  <= 1'b1;
            end else begin
              state_reg <= ENDED;
              ended_reg <= 1'b1;
            end
          end else if (count_next == CNT_W'(SLOTS)) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            buffer_reg      <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            end_pending_reg <= 1'b0;
            if (out_last) begin
              state_reg <= ENDED;
              ended_reg <= 1'b1;
            end else begin
              state_reg <= FILL;
            end
          end else if (test_ending) begin
            end_pending_reg <= 1'b1;
          end
        end
        ENDED: begin
          state_reg <= ENDED;
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/video_system_cpu_trace_packer.md
VIDEO_SYSTEM_CPU_TRACE_PACKER -- requirements
Module: video_system_cpu_trace_packer

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, on the ports named clk and reset.
REQ-002 Parameter FRAG_W, default 2: width of one trace fragment in bits; legal range 1..8.
REQ-003 Parameter SLOTS, default 15: number of fragments packed per output word; legal range 2..32.
REQ-004 Parameter CNT_W, default 4: width of the fragment count; SHALL be at least clog2(SLOTS+1).
REQ-005 clk  input  1: clock; all state is updated on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 frag_valid  input  1: a trace fragment is offered this cycle.
REQ-008 frag_data  input  FRAG_W: fragment payload.
REQ-009 frag_ready  output  1: the block accepts a fragment this cycle.
REQ-010 test_ending  input  1: single-cycle request to flush the partial word and end the capture.
REQ-011 dct_buffer  output  FRAG_W*SLOTS: packed word; slot 0 occupies the LSBs.
REQ-012 dct_count  output  CNT_W: number of valid slots in dct_buffer.
REQ-013 out_valid  output  1: dct_buffer and dct_count are presented to the consumer.
REQ-014 out_ready  input  1: the consumer accepts the presented word.
REQ-015 out_last  output  1: the presented word is the final word of the capture.
REQ-016 test_has_ended  output  1: the capture has fully drained.

Function
REQ-017 The block SHALL implement three states: FILL, HOLD and ENDED.
REQ-018 An accept SHALL occur on any cycle with frag_valid=1 and frag_ready=1.
REQ-019 frag_ready SHALL be 1 in FILL and 0 in HOLD and ENDED.
REQ-020 In FILL, each accept SHALL write frag_data into slot dct_count and increment dct_count by 1 on the same edge.
REQ-021 An accept that brings dct_count to SLOTS SHALL move the block to HOLD on that edge, with out_valid=1 from the next cycle (1-cycle latency).
REQ-022 On test_ending=1 in FILL, including any fragment accepted in the same cycle, the block SHALL go to HOLD with out_last=1 if the resulting count is greater than 0, else go directly to ENDED.
REQ-023 Unwritten slots of dct_buffer SHALL read as 0.
REQ-024 In HOLD, dct_buffer, dct_count and out_last SHALL remain stable until out_valid and out_ready are both 1.
REQ-025 The out_valid/out_ready handshake SHALL clear dct_buffer to 0 and dct_count to 0, and SHALL move the block to ENDED if out_last=1, else to FILL.
REQ-026 test_ending=1 during HOLD SHALL set an end-pending flag, so that the held word is emitted with out_last=1 if it has not yet been accepted; a test_ending that coincides with the handshake SHALL be applied to that word.
REQ-027 A word SHALL be emitted with out_last=1 only once: after the final handshake the block SHALL enter ENDED and SHALL not return to FILL.
REQ-028 In ENDED, test_has_ended SHALL be 1 and out_valid SHALL be 0, and the block SHALL remain in ENDED until reset; test_ending SHALL be ignored.
REQ-029 Fragments offered while frag_ready=0 SHALL NOT be consumed, and SHALL NOT be counted or lost.
REQ-030 No output word SHALL ever be duplicated or skipped.

Reset
REQ-031 While reset=1, the state SHALL become FILL, and dct_buffer, dct_count, out_valid, out_last, test_has_ended and the end-pending flag SHALL all become 0.
REQ-032 While reset=1, frag_ready SHALL be 0; it SHALL be 1 on the first cycle after reset deasserts.
REQ-033 Reset SHALL take priority over all other inputs, and reset asserted mid-HOLD SHALL discard the held word without a handshake.

Verification
REQ-034 Default parameters; 15 accepts of frag_data=i mod 4 with out_ready=1 -> out_valid=1 one cycle after the 15th accept; dct_count=15; slot i=i mod 4; out_last=0.
REQ-035 3 accepts followed by a test_ending pulse -> dct_count=3, upper 24 bits 0, out_last=1; after the handshake, test_has_ended=1 and frag_ready=0 permanently.
REQ-036 Full word held with out_ready=0 for 10 cycles while frag_valid=1 -> frag_ready=0 and outputs stable; the next accept after the handshake lands in slot 0.
REQ-037 test_ending with count 0 -> ENDED next cycle; out_valid never 1.
REQ-038 The 15th accept coincides with test_ending -> a single word, count=15, out_last=1.
REQ-039 Reset in HOLD -> all outputs 0 next cycle; FRAG_W=4, SLOTS=8 repeats REQ-034 with 8-slot words.
